// File: rtl/npc_redirect_unit_if.sv
// npc_redirect_unit_if
//   Bundles the EX-stage decode inputs and the fetch-side results of npc_redirect_unit.
//   master : pipeline side (drives stall and the EX operands, observes pc/strobes/stats)
//   slave  : npc_redirect_unit itself
//   Signals: stall, ex_valid, npc_sel[1:0], br_funct3[2:0], rs1, rs2, alu, pc_imm (to unit);
//            pc, redirect, flush[FLUSH_DEPTH-1:0], misalign, br_cnt, taken_cnt (from unit).
interface npc_redirect_unit_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
);
    logic                   stall;
    logic                   ex_valid;
    logic [1:0]             npc_sel;
    logic [2:0]             br_funct3;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [XLEN-1:0]        alu;
    logic [XLEN-1:0]        pc_imm;

    logic [XLEN-1:0]        pc;
    logic                   redirect;
    logic [FLUSH_DEPTH-1:0] flush;
    logic                   misalign;
    logic [CNT_W-1:0]       br_cnt;
    logic [CNT_W-1:0]       taken_cnt;

    modport master (
        output stall, ex_valid, npc_sel, br_funct3, rs1, rs2, alu, pc_imm,
        input  pc, redirect, flush, misalign, br_cnt, taken_cnt
    );

    modport slave (
        input  stall, ex_valid, npc_sel, br_funct3, rs1, rs2, alu, pc_imm,
        output pc, redirect, flush, misalign, br_cnt, taken_cnt
    );
endinterface

// File: rtl/npc_redirect_unit.sv
// npc_redirect_unit
//   Owns the fetch PC. Resolves JAL/JALR and all six RV32I branch conditions from EX
//   operands, issues a redirect plus per-stage flush strobes in the decode cycle, holds a
//   redirect that lands during a front-end stall until the stall releases, and keeps
//   saturating branch statistics.
//   Ports: clk, rst (synchronous, active high), bus (npc_redirect_unit_if.slave).
//   Optional feature: define NPC_MISALIGN_TRAP_EN to send misaligned taken targets to
//   TRAP_VEC and pulse misalign in the decode cycle; otherwise misalign is tied to 0.
module npc_redirect_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
`ifdef NPC_MISALIGN_TRAP_EN
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100),
`endif
    parameter int unsigned     FLUSH_DEPTH = 2,
    parameter int unsigned     CNT_W       = 16
) (
    input logic                clk,
    input logic                rst,
    npc_redirect_unit_if.slave bus
);

    localparam logic [1:0] SelJal    = 2'd1;
    localparam logic [1:0] SelJalr   = 2'd2;
    localparam logic [1:0] SelBranch = 2'd3;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pend_v_q, pend_v_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             br_cond;
    logic             decode_en;
    logic             take;
    logic             misalign;
    logic [XLEN-1:0]  raw_target;
    logic [XLEN-1:0]  target;

    always_comb begin
        br_cond = 1'b0;
        case (bus.br_funct3)
            3'b000:  br_cond = (bus.rs1 == bus.rs2);
            3'b001:  br_cond = (bus.rs1 != bus.rs2);
            3'b100:  br_cond = ($signed(bus.rs1) <  $signed(bus.rs2));
            3'b101:  br_cond = ($signed(bus.rs1) >= $signed(bus.rs2));
            3'b110:  br_cond = (bus.rs1 <  bus.rs2);
            3'b111:  br_cond = (bus.rs1 >= bus.rs2);
            default: br_cond = 1'b0;
        endcase
    end

    // A held redirect owns the front end: new EX instructions are ignored until it lands.
    assign decode_en = bus.ex_valid & ~pend_v_q;

    always_comb begin
        take       = 1'b0;
        raw_target = bus.pc_imm;
        if (decode_en) begin
            case (bus.npc_sel)
                SelJal:    take = 1'b1;
                SelJalr: begin
                    take       = 1'b1;
                    raw_target = {bus.alu[XLEN-1:1], 1'b0};
                end
                SelBranch: take = br_cond;
                default:   take = 1'b0;
            endcase
        end
    end

`ifdef NPC_MISALIGN_TRAP_EN
    assign misalign = take & (raw_target[1:0] != 2'b00);
    assign target   = misalign ? TRAP_VEC : raw_target;
`else
    assign misalign = 1'b0;
    assign target   = raw_target;
`endif

    always_comb begin
        pc_d      = pc_q + XLEN'(4);
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        if (take && !bus.stall) begin
            pc_d = target;
        end else if (take) begin
            pc_d      = pc_q;
            pend_v_d  = 1'b1;
            pend_pc_d = target;
        end else if (pend_v_q && !bus.stall) begin
            pc_d     = pend_pc_q;
            pend_v_d = 1'b0;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (decode_en && (bus.npc_sel == SelBranch)) begin
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (br_cond && (taken_cnt_q != '1)) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pend_v_q    <= 1'b0;
            pend_pc_q   <= '0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_v_q    <= pend_v_d;
            pend_pc_q   <= pend_pc_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.redirect  = take;
    assign bus.flush     = {FLUSH_DEPTH{take}};
    assign bus.misalign  = misalign;
    assign bus.br_cnt    = br_cnt_q;
    assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_npc_redirect_unit.sv
// tb_npc_redirect_unit
//   Directed scenarios plus a randomized run against a queue-based reference model of the
//   next-PC rules. CNT_W is 4 so counter saturation is reachable.
//   Honours NPC_MISALIGN_TRAP_EN the same way as the design.
module tb_npc_redirect_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FD    = 2;
    localparam int unsigned CW    = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP   = 32'h0000_0100;
    localparam int          CMAX   = (1 << CW) - 1;

    logic clk;
    logic rst;

    npc_redirect_unit_if #(.XLEN(XLEN), .FLUSH_DEPTH(FD), .CNT_W(CW)) bus ();

    npc_redirect_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RST_PC),
        .FLUSH_DEPTH(FD),
        .CNT_W      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    int          m_br;
    int          m_taken;
    bit          m_take;
    bit          m_mis;
    bit          m_cond;
    logic [31:0] m_tgt;

    function automatic bit branch_rule(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        longint sa = longint'(int'(a));
        longint sb = longint'(int'(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_decode();
        m_take = 1'b0;
        m_mis  = 1'b0;
        m_cond = branch_rule(bus.br_funct3, bus.rs1, bus.rs2);
        m_tgt  = bus.pc_imm;
        if (bus.ex_valid && m_pend.size() == 0) begin
            if (bus.npc_sel == 2'd1) m_take = 1'b1;
            if (bus.npc_sel == 2'd2) begin
                m_take = 1'b1;
                m_tgt  = bus.alu - (bus.alu % 2);
            end
            if (bus.npc_sel == 2'd3) m_take = m_cond;
        end
`ifdef NPC_MISALIGN_TRAP_EN
        if (m_take && (m_tgt % 4) != 0) begin
            m_mis = 1'b1;
            m_tgt = TRAP;
        end
`endif
    endfunction

    function automatic void model_advance();
        if (rst) begin
            m_pc = RST_PC;
            m_pend.delete();
            m_br = 0;
            m_taken = 0;
            return;
        end
        if (bus.ex_valid && bus.npc_sel == 2'd3 && m_pend.size() == 0) begin
            if (m_br < CMAX) m_br++;
            if (m_cond && m_taken < CMAX) m_taken++;
        end
        if (m_take && !bus.stall) m_pc = m_tgt;
        else if (m_take) m_pend.push_back(m_tgt);
        else if (m_pend.size() != 0 && !bus.stall) m_pc = m_pend.pop_front();
        else if (!bus.stall) m_pc = m_pc + 32'd4;
    endfunction

    task automatic drive(input logic r, input logic st, input logic ev, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] al, input logic [31:0] pi);
        @(negedge clk);
        rst           = r;
        bus.stall     = st;
        bus.ex_valid  = ev;
        bus.npc_sel   = sel;
        bus.br_funct3 = f3;
        bus.rs1       = a;
        bus.rs2       = b;
        bus.alu       = al;
        bus.pc_imm    = pi;
        #1;
        model_decode();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tests_run++;
        if (bus.pc !== RST_PC) begin
            tests_failed++;
            $display("FAIL reset_pc: got %h want %h", bus.pc, RST_PC);
        end
        tests_run++;
        if (bus.br_cnt !== 4'h0 || bus.taken_cnt !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", bus.br_cnt, bus.taken_cnt);
        end
        tests_run++;
        if (bus.redirect !== 1'b0 || bus.flush !== 2'b00 || bus.misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b/%b/%b want 0/00/0",
                     bus.redirect, bus.flush, bus.misalign);
        end
        tick();
        tests_run++;
        if (bus.pc !== 32'h4) begin
            tests_failed++;
            $display("FAIL freerun_pc4: got %h want 00000004", bus.pc);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tests_run++;
        if (bus.pc !== 32'h8) begin
            tests_failed++;
            $display("FAIL freerun_pc8: got %h want 00000008", bus.pc);
        end
    endtask

    task automatic test_signed_unsigned();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 2'd3, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40);
        tests_run++;
        if (bus.redirect !== 1'b1 || bus.flush !== 2'b11) begin
            tests_failed++;
            $display("FAIL blt_redirect: got %b/%b want 1/11", bus.redirect, bus.flush);
        end
        tick();
        tests_run++;
        if (bus.pc !== 32'h40 || bus.br_cnt !== 4'd1 || bus.taken_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL blt_update: got pc=%h br=%0d tk=%0d want 40/1/1",
                     bus.pc, bus.br_cnt, bus.taken_cnt);
        end
        drive(1'b0, 1'b0, 1'b1, 2'd3, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40);
        tests_run++;
        if (bus.redirect !== 1'b0 || bus.flush !== 2'b00) begin
            tests_failed++;
            $display("FAIL bltu_redirect: got %b/%b want 0/00", bus.redirect, bus.flush);
        end
        tick();
        tests_run++;
        if (bus.pc !== 32'h44 || bus.br_cnt !== 4'd2 || bus.taken_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL bltu_update: got pc=%h br=%0d tk=%0d want 44/2/1",
                     bus.pc, bus.br_cnt, bus.taken_cnt);
        end
    endtask

    task automatic test_jalr();
        logic [31:0] exp_pc;
        logic        exp_mis;
`ifdef NPC_MISALIGN_TRAP_EN
        exp_pc  = 32'h0000_0100;
        exp_mis = 1'b1;
`else
        exp_pc  = 32'h0000_0102;
        exp_mis = 1'b0;
`endif
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 32'd0, 32'd0, 32'h0000_0103, 32'h0);
        tests_run++;
        if (bus.redirect !== 1'b1 || bus.misalign !== exp_mis) begin
            tests_failed++;
            $display("FAIL jalr_decode: got redir=%b mis=%b want 1/%b",
                     bus.redirect, bus.misalign, exp_mis);
        end
        tick();
        tests_run++;
        if (bus.pc !== exp_pc) begin
            tests_failed++;
            $display("FAIL jalr_target: got %h want %h", bus.pc, exp_pc);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tests_run++;
        if (bus.misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL jalr_mis_pulse: got %b want 0", bus.misalign);
        end
        tick();
    endtask

    task automatic test_stall_redirect();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 2'd1, 3'd0, 32'd0, 32'd0, 32'd0, 32'h200);
        tests_run++;
        if (bus.redirect !== 1'b1 || bus.flush !== 2'b11) begin
            tests_failed++;
            $display("FAIL stall_jal_strobe: got %b/%b want 1/11", bus.redirect, bus.flush);
        end
        tick();
        tests_run++;
        if (bus.pc !== RST_PC) begin
            tests_failed++;
            $display("FAIL stall_hold: got %h want %h", bus.pc, RST_PC);
        end
        drive(1'b0, 1'b1, 1'b1, 2'd1, 3'd0, 32'd0, 32'd0, 32'd0, 32'h300);
        tests_run++;
        if (bus.redirect !== 1'b0 || bus.flush !== 2'b00) begin
            tests_failed++;
            $display("FAIL pend_ignore: got %b/%b want 0/00", bus.redirect, bus.flush);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 32'd0, 32'd0, 32'd0, 32'h300);
        tests_run++;
        if (bus.redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_release_ignore: got %b want 0", bus.redirect);
        end
        tick();
        tests_run++;
        if (bus.pc !== 32'h200) begin
            tests_failed++;
            $display("FAIL pend_release: got %h want 00000200", bus.pc);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tests_run++;
        if (bus.pc !== 32'h204) begin
            tests_failed++;
            $display("FAIL pend_after: got %h want 00000204", bus.pc);
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 2'd1, 3'd0, 32'd0, 32'd0, 32'd0, 32'h200);
        tick();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tests_run++;
        if (bus.pc !== RST_PC) begin
            tests_failed++;
            $display("FAIL rst_pend_pc: got %h want %h", bus.pc, RST_PC);
        end
        drive(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tests_run++;
        if (bus.pc !== RST_PC + 32'd4) begin
            tests_failed++;
            $display("FAIL rst_pend_discard: got %h want %h", bus.pc, RST_PC + 32'd4);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd3, 3'b000, 32'd5, 32'd5, 32'd0, 32'h40);
            tick();
        end
        tests_run++;
        if (bus.br_cnt !== 4'hF || bus.taken_cnt !== 4'hF) begin
            tests_failed++;
            $display("FAIL sat_reach: got %h/%h want F/F", bus.br_cnt, bus.taken_cnt);
        end
        drive(1'b0, 1'b0, 1'b1, 2'd3, 3'b000, 32'd5, 32'd5, 32'd0, 32'h40);
        tick();
        tests_run++;
        if (bus.br_cnt !== 4'hF || bus.taken_cnt !== 4'hF) begin
            tests_failed++;
            $display("FAIL sat_hold: got %h/%h want F/F", bus.br_cnt, bus.taken_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, pi;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
            if ($urandom_range(0, 3) == 0) b = ~a;
            pi = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), a, b, $urandom(), pi);
            tests_run++;
            if (bus.redirect !== m_take || bus.flush !== {FD{m_take}}) begin
                tests_failed++;
                $display("FAIL rnd_redirect[%0d]: got %b/%b want %b", i, bus.redirect,
                         bus.flush, m_take);
            end
            tests_run++;
            if (bus.misalign !== m_mis) begin
                tests_failed++;
                $display("FAIL rnd_misalign[%0d]: got %b want %b", i, bus.misalign, m_mis);
            end
            tick();
            tests_run++;
            if (bus.pc !== m_pc) begin
                tests_failed++;
                $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.pc, m_pc);
            end
            tests_run++;
            if (int'(bus.br_cnt) != m_br || int'(bus.taken_cnt) != m_taken) begin
                tests_failed++;
                $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bus.br_cnt,
                         bus.taken_cnt, m_br, m_taken);
            end
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        m_pc          = RST_PC;
        m_br          = 0;
        m_taken       = 0;
        rst           = 1'b1;
        bus.stall     = 1'b0;
        bus.ex_valid  = 1'b0;
        bus.npc_sel   = 2'd0;
        bus.br_funct3 = 3'd0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.alu       = '0;
        bus.pc_imm    = '0;

        test_reset();
        test_signed_unsigned();
        test_jalr();
        test_stall_redirect();
        test_reset_pending();
        test_saturation();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/npc_redirect_unit.md
# npc_redirect_unit

Parametrised next-PC unit for the pipelined core. It owns the fetch PC register, resolves all six RV32I branch conditions from EX-stage operands instead of relying on a precomputed zero flag, and handles JAL/JALR. It holds a redirect that arrives during a front-end stall until the stall releases, issues per-stage flush strobes, and keeps saturating branch statistics. It sits between the EX stage and the IF PC mux, replacing the single-flag combinational next-PC selector.

## Interface
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_VEC, 32'h0000_0100, redirect target on misaligned target (macro only)
- FLUSH_DEPTH, 2, number of younger pipeline registers flushed on redirect
- CNT_W, 16, width of the statistics counters

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  front-end hold; PC must not advance
- ex_valid  in  1  EX-stage instruction valid
- npc_sel  in  2  0 = none (PC+4), 1 = JAL, 2 = JALR, 3 = BRANCH
- br_funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- rs1  in  XLEN  branch operand 1
- rs2  in  XLEN  branch operand 2
- alu  in  XLEN  JALR sum rs1+imm
- pc_imm  in  XLEN  EX PC + immediate
- pc  out  XLEN  current fetch PC (register)
- redirect  out  1  redirect accepted this cycle
- flush  out  FLUSH_DEPTH  per-stage flush strobes, all bits equal
- misalign  out  1  misaligned-target pulse (macro only, else 0)
- br_cnt  out  CNT_W  executed conditional branches
- taken_cnt  out  CNT_W  taken conditional branches

## Operation
- Decode (combinational, only when ex_valid=1 and no pending redirect):
  - JAL: take, target = pc_imm.
  - JALR: take, target = {alu[XLEN-1:1],1'b0}.
  - BRANCH: take = compare(br_funct3, rs1, rs2), target = pc_imm. Signed compare for BLT/BGE, unsigned for BLTU/BGEU. Undefined funct3 values (010, 011) mean not taken.
  - npc_sel=0, or ex_valid=0: no take.
- redirect = flush bits = take. The strobes are combinational in the decode cycle, so the younger stages clear on the same edge.
- PC update on each rising edge, highest priority first:
  1. rst: load RESET_PC.
  2. take and not stall: load target.
  3. take and stall: keep pc; set pend_v=1 and pend_pc=target.
  4. pend_v and not stall: load pend_pc; clear pend_v.
  5. stall: hold.
  6. Otherwise: pc+4, wrapping modulo 2^XLEN.
- While pend_v=1, ex_valid is ignored: no new take, redirect, or flush.
- Counters, applied when ex_valid=1, npc_sel=3, and no pending redirect:
  - br_cnt increments.
  - taken_cnt increments if taken.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset values: pc=RESET_PC, pend_v=0, br_cnt=0, taken_cnt=0, redirect=0, flush=0, misalign=0.
- Redirect latency: target appears on pc one cycle after the decode cycle when not stalled. When stalled, target appears on the first edge with stall=0.
- If stall falls in the same cycle a pending redirect exists, pend_pc is loaded at that edge.
- rst asserted mid-stall or with pend_v=1: pending redirect is discarded and pc=RESET_PC on the next edge.
- Statistics change on the edge following the decode cycle.

## Configuration
- NPC_MISALIGN_TRAP_EN defined:
  - A taken target with target[1:0]≠0 loads TRAP_VEC instead of the target. For JALR the check applies after bit 0 is cleared, so only bit 1 matters.
  - misalign pulses for one cycle, the decode cycle. redirect and flush behave as for a normal take.
  - The stall/pending rules apply to TRAP_VEC.
- Not defined: the target is used as computed; misalign is tied to 0.

## Test plan
- Reset then free run: rst high 2 cycles, release -> pc = 0x0, 0x4, 0x8 on successive cycles; counters 0.
- BLT signed vs BLTU: rs1=0xFFFF_FFFF, rs2=1, pc_imm=0x40.
  - funct3=100 -> redirect=1, flush=2'b11, next pc=0x40, taken_cnt=1.
  - funct3=110 -> no redirect, pc+4, br_cnt=2, taken_cnt=1.
- JALR bit clearing: alu=0x0000_0103, npc_sel=2 -> next pc=0x0000_0102. With NPC_MISALIGN_TRAP_EN: pc=0x100, misalign=1 for 1 cycle.
- Redirect under stall: stall=1 with JAL to 0x200 -> pc held and flush=1 that cycle. Another JAL to 0x300 while stalled -> ignored. Stall drops 3 cycles later -> pc=0x200 next edge.
- Reset with pending redirect: pend_v=1, assert rst -> pc=RESET_PC. After release, stall drop -> pc=RESET_PC+4, not the stale target.
- Saturation with CNT_W=4: 17 taken BEQ (rs1=rs2) -> br_cnt=taken_cnt=4'hF, stays 4'hF.
